// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front end with a small decoupling FIFO between the
// instruction memory and the decode stage. While fetching, every cycle with
// room in the queue captures {Instr, PC} at the tail and advances PC by 4.
// Decode consumes from the head. A taken branch from execute flushes the
// whole queue and redirects PC.
//
// Parameters
//   DATA_W    instruction / address width
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk            single clock
//   reset          asynchronous active-high reset
//   start          fetch enable (level)
//   PC             fetch address to instruction memory
//   Instr          memory data, combinational from PC in the same cycle
//   StallD         decode is not consuming the head entry
//   FlushD         discard the head entry
//   BranchTakenE   redirect request (highest priority)
//   BranchTargetE  redirect address
//   InstrD         head instruction (0 when the queue is empty)
//   PCPlus8D       head address + 8 (0 when the queue is empty)
//   ValidD         head entry valid (queue not empty)
//   Count          entries currently held
//   Full / Empty   Count == DEPTH / Count == 0
//   FetchCnt       pushes since reset (only with FETCH_QUEUE_PERF_EN)
//   RedirectCnt    accepted redirects since reset (only with FETCH_QUEUE_PERF_EN)
//
// Optional feature
//   Define FETCH_QUEUE_PERF_EN to add the FetchCnt / RedirectCnt counters and
//   ports. Without it the block behaves identically minus those ports.
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic [DATA_W-1:0]            PC,
    input  logic [DATA_W-1:0]            Instr,
    input  logic                         StallD,
    input  logic                         FlushD,
    input  logic                         BranchTakenE,
    input  logic [DATA_W-1:0]            BranchTargetE,
    output logic [DATA_W-1:0]            InstrD,
    output logic [DATA_W-1:0]            PCPlus8D,
    output logic                         ValidD,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Full,
`ifdef FETCH_QUEUE_PERF_EN
    output logic [31:0]                  FetchCnt,
    output logic [31:0]                  RedirectCnt,
`endif
    output logic                         Empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t              state;
    state_t              stateNext;

    logic [DATA_W-1:0]   instrMem [DEPTH];
    logic [DATA_W-1:0]   pcMem    [DEPTH];

    logic [PTR_W-1:0]    headPtr;
    logic [PTR_W-1:0]    tailPtr;
    logic [CNT_W-1:0]    count;
    logic [DATA_W-1:0]   pcReg;

    logic                doPush;
    logic                doPop;

    // Next-state decision for the fetch FSM. The cycle in which start rises
    // is already a FETCH cycle (so the very first fetch comes from RESET_PC
    // in that cycle), and the cycle in which start drops is already IDLE
    // (so PC stops advancing immediately).
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start)  stateNext = FETCH;
            FETCH:   if (!start) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // FSM state register. Queue contents are untouched by state changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    assign Full  = (count == CNT_W'(DEPTH));
    assign Empty = (count == '0);

    // A redirect wipes the queue, so neither a push nor a pop is meaningful
    // in that cycle. Pushing into a full queue is allowed only when the head
    // leaves in the same cycle, which is what lets a full, non-stalled
    // queue keep fetching at one instruction per cycle.
    assign doPop  = !Empty && (!StallD || FlushD) && !BranchTakenE;
    assign doPush = (stateNext == FETCH) && !BranchTakenE && (!Full || doPop);

    // Pointers, occupancy and fetch PC. Pointer arithmetic wraps naturally
    // because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
            pcReg   <= RESET_PC;
        end else if (BranchTakenE) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
            pcReg   <= BranchTargetE;
        end else begin
            if (doPush) begin
                tailPtr <= tailPtr + PTR_W'(1);
                pcReg   <= pcReg + DATA_W'(4);
            end
            if (doPop) begin
                headPtr <= headPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage. No reset is needed: an entry is only ever observed
    // after it has been written, because occupancy gates the outputs.
    always_ff @(posedge clk) begin
        if (doPush) begin
            instrMem[tailPtr] <= Instr;
            pcMem[tailPtr]    <= pcReg;
        end
    end

    // Head presentation comes straight from registered storage, so a freshly
    // pushed entry is visible no earlier than the following cycle. Outputs
    // are forced to zero when empty, which also makes them drop to zero the
    // moment reset clears the occupancy.
    assign PC       = pcReg;
    assign Count    = count;
    assign ValidD   = !Empty;
    assign InstrD   = ValidD ? instrMem[headPtr] : '0;
    assign PCPlus8D = ValidD ? (pcMem[headPtr] + DATA_W'(8)) : '0;

`ifdef FETCH_QUEUE_PERF_EN
    // Free-running event counters; they wrap at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FetchCnt    <= '0;
            RedirectCnt <= '0;
        end else begin
            if (doPush) begin
                FetchCnt <= FetchCnt + 32'd1;
            end
            if (BranchTakenE) begin
                RedirectCnt <= RedirectCnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Self-checking bench for fetch_queue (DATA_W=32, DEPTH=4, RESET_PC=0).
// Instruction memory is a small random table indexed by PC[7:2]. A queue
// based reference model tracks the fetch PC and the FIFO contents.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic        StallD;
    logic        FlushD;
    logic        BranchTakenE;
    logic [31:0] BranchTargetE;
    logic [31:0] InstrD;
    logic [31:0] PCPlus8D;
    logic        ValidD;
    logic [2:0]  Count;
    logic        Full;
    logic        Empty;

    logic [31:0] mem [0:63];
    entry_t      q[$];
    logic [31:0] mpc;

    int testsRun;
    int testsFailed;

    fetch_queue #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .PC           (PC),
        .Instr        (Instr),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .BranchTakenE (BranchTakenE),
        .BranchTargetE(BranchTargetE),
        .InstrD       (InstrD),
        .PCPlus8D     (PCPlus8D),
        .ValidD       (ValidD),
        .Count        (Count),
        .Full         (Full),
        .Empty        (Empty)
    );

    // Combinational instruction memory
    assign Instr = mem[PC[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, clock it, advance the reference model
    task automatic applyStimulus(input logic s, input logic st, input logic fl,
                                 input logic br, input logic [31:0] tgt);
        logic   pop;
        logic   push;
        entry_t e;
        start         = s;
        StallD        = st;
        FlushD        = fl;
        BranchTakenE  = br;
        BranchTargetE = tgt;
        @(posedge clk);
        if (br) begin
            q.delete();
            mpc = tgt;
        end else begin
            pop  = (q.size() > 0) && (!st || fl);
            push = s && ((q.size() < DEPTH) || pop);
            if (pop) void'(q.pop_front());
            if (push) begin
                e.instr = mem[mpc[7:2]];
                e.pc    = mpc;
                q.push_back(e);
                mpc = mpc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic applyReset();
        start = 0; StallD = 0; FlushD = 0; BranchTakenE = 0; BranchTargetE = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        mpc = 32'h0;
    endtask

    task automatic test_reset();
        #12;
        testsRun++; if (Count !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_count: got %0d expected 0", Count); end
        testsRun++; if (Empty !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_empty: got %b expected 1", Empty); end
        testsRun++; if (Full !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_full: got %b expected 0", Full); end
        testsRun++; if (ValidD !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %b expected 0", ValidD); end
        testsRun++; if (InstrD !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_instrd: got %h expected 0", InstrD); end
        testsRun++; if (PCPlus8D !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_pcplus8: got %h expected 0", PCPlus8D); end
        testsRun++; if (PC !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_pc: got %h expected 0", PC); end
        applyReset();
    endtask

    task automatic test_basic_fetch();
        applyReset();
        start = 1'b1;
        #1;
        testsRun++; if (ValidD !== 1'b0) begin testsFailed++; $display("[TB] FAIL nobypass_valid: got %b expected 0", ValidD); end
        testsRun++; if (PC !== 32'h0) begin testsFailed++; $display("[TB] FAIL first_pc: got %h expected 0", PC); end
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1, 0, 0, 0, 32'h0);
            testsRun++; if (ValidD !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_valid[%0d]: got %b expected 1", k, ValidD); end
            testsRun++; if (PC !== 32'(4*k)) begin testsFailed++; $display("[TB] FAIL basic_pc[%0d]: got %h expected %h", k, PC, 32'(4*k)); end
            testsRun++; if (InstrD !== mem[k-1]) begin testsFailed++; $display("[TB] FAIL basic_instrd[%0d]: got %h expected %h", k, InstrD, mem[k-1]); end
            testsRun++; if (PCPlus8D !== 32'(4*(k-1)+8)) begin testsFailed++; $display("[TB] FAIL basic_pcplus8[%0d]: got %h expected %h", k, PCPlus8D, 32'(4*(k-1)+8)); end
        end
    endtask

    task automatic test_full_stall();
        int expCount;
        applyReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, 0, 0, 32'h0);
            expCount = (i + 1 < 4) ? i + 1 : 4;
            testsRun++; if (Count !== 3'(expCount)) begin testsFailed++; $display("[TB] FAIL stall_count[%0d]: got %0d expected %0d", i, Count, expCount); end
        end
        testsRun++; if (Full !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_full: got %b expected 1", Full); end
        testsRun++; if (PC !== 32'h10) begin testsFailed++; $display("[TB] FAIL stall_pc_hold: got %h expected 10", PC); end
        for (int i = 0; i < 4; i++) begin
            testsRun++; if (PCPlus8D !== 32'(4*i+8)) begin testsFailed++; $display("[TB] FAIL drain_order[%0d]: got %h expected %h", i, PCPlus8D, 32'(4*i+8)); end
            testsRun++; if (InstrD !== mem[i]) begin testsFailed++; $display("[TB] FAIL drain_instr[%0d]: got %h expected %h", i, InstrD, mem[i]); end
            applyStimulus(0, 0, 0, 0, 32'h0);
        end
        testsRun++; if (Empty !== 1'b1) begin testsFailed++; $display("[TB] FAIL drain_empty: got %b expected 1", Empty); end
        applyStimulus(0, 0, 1, 0, 32'h0);
        testsRun++; if (Count !== 3'd0) begin testsFailed++; $display("[TB] FAIL empty_pop_count: got %0d expected 0", Count); end
        testsRun++; if (PC !== 32'h10) begin testsFailed++; $display("[TB] FAIL empty_pop_pc: got %h expected 10", PC); end
    endtask

    task automatic test_redirect();
        applyReset();
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 32'h0);
        testsRun++; if (Count !== 3'd3) begin testsFailed++; $display("[TB] FAIL redirect_pre_count: got %0d expected 3", Count); end
        applyStimulus(1, 1, 0, 1, 32'h100);
        testsRun++; if (Count !== 3'd0) begin testsFailed++; $display("[TB] FAIL redirect_count: got %0d expected 0", Count); end
        testsRun++; if (ValidD !== 1'b0) begin testsFailed++; $display("[TB] FAIL redirect_valid: got %b expected 0", ValidD); end
        testsRun++; if (PC !== 32'h100) begin testsFailed++; $display("[TB] FAIL redirect_pc: got %h expected 100", PC); end
        applyStimulus(1, 1, 0, 0, 32'h0);
        testsRun++; if (Count !== 3'd1) begin testsFailed++; $display("[TB] FAIL redirect_push_count: got %0d expected 1", Count); end
        testsRun++; if (PCPlus8D !== 32'h108) begin testsFailed++; $display("[TB] FAIL redirect_push_pc: got %h expected 108", PCPlus8D); end
        testsRun++; if (InstrD !== mem[6'h0]) begin testsFailed++; $display("[TB] FAIL redirect_push_instr: got %h expected %h", InstrD, mem[6'h0]); end
        testsRun++; if (PC !== 32'h104) begin testsFailed++; $display("[TB] FAIL redirect_next_pc: got %h expected 104", PC); end
    endtask

    task automatic test_redirect_priority();
        applyReset();
        applyStimulus(1, 1, 0, 0, 32'h0);
        applyStimulus(1, 1, 0, 0, 32'h0);
        applyStimulus(1, 1, 1, 1, 32'h200);
        testsRun++; if (Count !== 3'd0) begin testsFailed++; $display("[TB] FAIL prio_count: got %0d expected 0", Count); end
        testsRun++; if (PC !== 32'h200) begin testsFailed++; $display("[TB] FAIL prio_pc: got %h expected 200", PC); end
        testsRun++; if (Empty !== 1'b1) begin testsFailed++; $display("[TB] FAIL prio_empty: got %b expected 1", Empty); end
    endtask

    task automatic test_full_throughput();
        applyReset();
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 32'h0);
        testsRun++; if (Full !== 1'b1) begin testsFailed++; $display("[TB] FAIL thru_full: got %b expected 1", Full); end
        applyStimulus(1, 0, 0, 0, 32'h0);
        testsRun++; if (Count !== 3'd4) begin testsFailed++; $display("[TB] FAIL thru_count: got %0d expected 4", Count); end
        testsRun++; if (PC !== 32'h14) begin testsFailed++; $display("[TB] FAIL thru_pc: got %h expected 14", PC); end
        testsRun++; if (PCPlus8D !== 32'hC) begin testsFailed++; $display("[TB] FAIL thru_head: got %h expected c", PCPlus8D); end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 32'h0);
            testsRun++; if (Count !== 3'(3-i)) begin testsFailed++; $display("[TB] FAIL thru_drain_count[%0d]: got %0d expected %0d", i, Count, 3-i); end
            testsRun++; if (PC !== 32'h14) begin testsFailed++; $display("[TB] FAIL thru_drain_pc[%0d]: got %h expected 14", i, PC); end
        end
        testsRun++; if (Empty !== 1'b1) begin testsFailed++; $display("[TB] FAIL thru_empty: got %b expected 1", Empty); end
    endtask

    task automatic test_async_reset();
        applyReset();
        applyStimulus(1, 1, 0, 0, 32'h0);
        applyStimulus(1, 1, 0, 0, 32'h0);
        testsRun++; if (Count !== 3'd2) begin testsFailed++; $display("[TB] FAIL areset_pre_count: got %0d expected 2", Count); end
        #3;
        reset = 1'b1;
        #1;
        testsRun++; if (Count !== 3'd0) begin testsFailed++; $display("[TB] FAIL areset_count: got %0d expected 0", Count); end
        testsRun++; if (ValidD !== 1'b0) begin testsFailed++; $display("[TB] FAIL areset_valid: got %b expected 0", ValidD); end
        testsRun++; if (InstrD !== 32'h0) begin testsFailed++; $display("[TB] FAIL areset_instrd: got %h expected 0", InstrD); end
        testsRun++; if (PCPlus8D !== 32'h0) begin testsFailed++; $display("[TB] FAIL areset_pcplus8: got %h expected 0", PCPlus8D); end
        testsRun++; if (PC !== 32'h0) begin testsFailed++; $display("[TB] FAIL areset_pc: got %h expected 0", PC); end
        applyReset();
    endtask

    task automatic test_random();
        logic        s, st, fl, br;
        logic [31:0] tgt;
        logic [31:0] expInstr;
        logic [31:0] expPc8;
        applyReset();
        for (int n = 0; n < 400; n++) begin
            s   = ($urandom_range(0, 3) != 0);
            st  = $urandom_range(0, 1) == 1;
            fl  = ($urandom_range(0, 7) == 0);
            br  = ($urandom_range(0, 15) == 0);
            tgt = $urandom & 32'hFFFF_FFFC;
            applyStimulus(s, st, fl, br, tgt);
            expInstr = (q.size() > 0) ? q[0].instr : 32'h0;
            expPc8   = (q.size() > 0) ? q[0].pc + 32'd8 : 32'h0;
            testsRun++; if (Count !== 3'(q.size())) begin testsFailed++; $display("[TB] FAIL rand_count[%0d]: got %0d expected %0d", n, Count, q.size()); end
            testsRun++; if (PC !== mpc) begin testsFailed++; $display("[TB] FAIL rand_pc[%0d]: got %h expected %h", n, PC, mpc); end
            testsRun++; if (ValidD !== (q.size() > 0)) begin testsFailed++; $display("[TB] FAIL rand_valid[%0d]: got %b expected %b", n, ValidD, q.size() > 0); end
            testsRun++; if (InstrD !== expInstr) begin testsFailed++; $display("[TB] FAIL rand_instrd[%0d]: got %h expected %h", n, InstrD, expInstr); end
            testsRun++; if (PCPlus8D !== expPc8) begin testsFailed++; $display("[TB] FAIL rand_pcplus8[%0d]: got %h expected %h", n, PCPlus8D, expPc8); end
            testsRun++; if (Full !== (q.size() == DEPTH)) begin testsFailed++; $display("[TB] FAIL rand_full[%0d]: got %b expected %b", n, Full, q.size() == DEPTH); end
            testsRun++; if (Empty !== (q.size() == 0)) begin testsFailed++; $display("[TB] FAIL rand_empty[%0d]: got %b expected %b", n, Empty, q.size() == 0); end
        end
    endtask

    initial begin
        testsRun      = 0;
        testsFailed   = 0;
        reset         = 1'b1;
        start         = 1'b0;
        StallD        = 1'b0;
        FlushD        = 1'b0;
        BranchTakenE  = 1'b0;
        BranchTargetE = 32'h0;
        mpc           = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;

        test_reset();
        test_basic_fetch();
        test_full_stall();
        test_redirect();
        test_redirect_priority();
        test_full_throughput();
        test_async_reset();
        test_random();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
